// File: rtl/parity_pkg.sv
// Shared definitions for the streaming frame-parity accumulator:
// frame state encoding, parity mode constants and a generic XOR reduction.
package parity_pkg;

  // IDLE: no partial frame held; ACC: at least one word of an open frame held
  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

  // Widest word xor_reduce accepts; narrower words are zero-extended,
  // which leaves the parity unchanged.
  localparam int XOR_MAX_W = 1024;

  // XOR-reduce an arbitrary-width word (callers zero-extend to XOR_MAX_W)
  function automatic logic xor_reduce(input logic [XOR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage : parity_pkg

// File: rtl/parity_tree.sv
// Purely combinational WIDTH-bit XOR reduction (word parity).
// Generalised form of the 16-input parity benchmark; kept as its own block
// so a pipelined variant can be dropped in later without touching the top.
module parity_tree
  import parity_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in_data,
  output logic             parity
);

  logic [XOR_MAX_W-1:0] w_ext;

  // Zero-extend into the reduction function's fixed argument width
  always_comb begin
    w_ext  = XOR_MAX_W'(in_data);
    parity = xor_reduce(w_ext);
  end

endmodule : parity_tree

// File: rtl/parity_frame_acc.sv
// Streaming frame parity accumulator.
// Folds the XOR-reduction of each accepted WIDTH-bit word into a running
// frame parity and emits one (parity, word count) result per frame on a
// backpressured output stream. A frame closes on in_last or on its
// FRAME_LEN-th word, whichever comes first.
// Optional build macro: PARITY_CHECK_EN adds exp_parity / parity_err.
module parity_frame_acc
  import parity_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             mode_odd,
`ifdef PARITY_CHECK_EN
  input  logic             exp_parity,
  output logic             parity_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

  state_t           r_state;
  logic             r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_mode;
  logic             r_out_valid;
  logic             r_out_parity;
  logic [CNT_W-1:0] r_out_count;
`ifdef PARITY_CHECK_EN
  logic             r_parity_err;
`endif

  logic             w_wp;
  logic             w_accept;
  logic             w_acc_eff;
  logic             w_mode_eff;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_close;
  logic             w_result;

  parity_tree #(
    .WIDTH (WIDTH)
  ) u_parity_tree (
    .in_data (in_data),
    .parity  (w_wp)
  );

  // Ready depends only on the output register draining, never on in_valid
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Effective frame context: a word arriving in IDLE starts from a clean
  // accumulator and uses the live mode input instead of the latched one
  always_comb begin
    w_acc_eff   = 1'b0;
    w_mode_eff  = mode_odd;
    w_count_inc = CNT_W'(1);
    if (r_state == ACC) begin
      w_acc_eff   = r_acc;
      w_mode_eff  = r_mode;
      w_count_inc = r_count + CNT_W'(1);
    end
    w_close  = in_last || (w_count_inc == FRAME_LEN_C);
    w_result = w_acc_eff ^ w_wp ^ w_mode_eff;
  end

  // Frame FSM, accumulator and registered result stream
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_acc        <= 1'b0;
      r_count      <= '0;
      r_mode       <= MODE_EVEN;
      r_out_valid  <= 1'b0;
      r_out_parity <= 1'b0;
      r_out_count  <= '0;
`ifdef PARITY_CHECK_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      // A consumed result is dropped unless a new close reloads it below
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (w_close) begin
          r_out_valid  <= 1'b1;
          r_out_parity <= w_result;
          r_out_count  <= w_count_inc;
`ifdef PARITY_CHECK_EN
          r_parity_err <= (w_result != exp_parity);
`endif
          r_acc        <= 1'b0;
          r_count      <= '0;
          r_state      <= IDLE;
        end else if (r_state == IDLE) begin
          r_acc   <= w_wp;
          r_count <= CNT_W'(1);
          r_mode  <= mode_odd;
          r_state <= ACC;
        end else begin
          r_acc   <= r_acc ^ w_wp;
          r_count <= w_count_inc;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_parity = r_out_parity;
  assign out_count  = r_out_count;
`ifdef PARITY_CHECK_EN
  assign parity_err = r_parity_err;
`endif

endmodule : parity_frame_acc
